// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: default sizing,
// FSM state encoding and the segment pattern table.
package seg_pkg;

    localparam int NDIG_DEFAULT       = 4;
    localparam int STABLE_CYC_DEFAULT = 4;

    // Dwell tracker states
    localparam logic [1:0] ST_IDLE   = 2'd0;  // no digit selected
    localparam logic [1:0] ST_SETTLE = 2'd1;  // counting identical samples
    localparam logic [1:0] ST_HELD   = 2'd2;  // captured, waiting for a change

    // Active-low a..g pattern (bit6 = a ... bit0 = g) that displays a given nibble
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'h0:    pat = 7'h01;
            4'h1:    pat = 7'h4F;
            4'h2:    pat = 7'h12;
            4'h3:    pat = 7'h06;
            4'h4:    pat = 7'h4C;
            4'h5:    pat = 7'h24;
            4'h6:    pat = 7'h20;
            4'h7:    pat = 7'h0F;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h04;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h60;
            4'hC:    pat = 7'h31;
            4'hD:    pat = 7'h42;
            4'hE:    pat = 7'h30;
            4'hF:    pat = 7'h38;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup: active-low a..g pattern to hex nibble.
// Patterns outside the 16-entry table are flagged as not legal.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       legal
);

    // Search the shared pattern table for a match
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (pattern == seg_pattern(4'(k))) begin
                nibble = 4'(k);
                legal  = 1'b1;
            end else begin
                nibble = nibble;
                legal  = legal;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed seven-segment display bus.
// Pins are registered once; a digit/pattern pair must stay identical for
// STABLE_CYC samples before it is captured, exactly once per dwell.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG       = NDIG_DEFAULT,
    parameter int STABLE_CYC = STABLE_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg_n,
    input  logic [NDIG-1:0]     dig_n,
    input  logic                clr,
    output logic [4*NDIG-1:0]   hex_out,
    output logic [NDIG-1:0]     dp_out,
    output logic [NDIG-1:0]     dig_valid,
    output logic                frame_done,
    output logic                err
);

    localparam int         IDXW    = $clog2(NDIG);
    localparam logic [7:0] CNT_TGT = 8'(STABLE_CYC);

    // Registered pin samples and dwell tracking
    logic [7:0]        samp_seg_r;
    logic [NDIG-1:0]   samp_dig_r;
    logic [7:0]        prev_seg_r;
    logic [IDXW-1:0]   prev_idx_r;
    logic [1:0]        state_r;
    logic [7:0]        cnt_r;
    logic              multi_r;
    logic [NDIG-1:0]   seen_r;

    // Sample classification
    logic [3:0]        low_cnt_s;
    logic [IDXW-1:0]   sel_idx_s;
    logic              sel_s;
    logic              multi_s;
    logic              same_s;
    logic [3:0]        nib_s;
    logic              legal_s;

    // Next-state values
    logic [1:0]        state_n_s;
    logic [7:0]        cnt_n_s;
    logic              capture_s;
    logic [4*NDIG-1:0] hex_n_s;
    logic [NDIG-1:0]   dp_n_s;
    logic [NDIG-1:0]   valid_n_s;
    logic [NDIG-1:0]   seen_n_s;
    logic [NDIG-1:0]   seen_upd_s;
    logic              frame_n_s;
    logic              err_n_s;

    seg7_to_hex u_lookup (
        .pattern (samp_seg_r[7:1]),
        .nibble  (nib_s),
        .legal   (legal_s)
    );

    // Count active enables in the registered sample and locate the selected digit
    always_comb begin
        low_cnt_s = 4'd0;
        sel_idx_s = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!samp_dig_r[i]) begin
                low_cnt_s = low_cnt_s + 4'd1;
                sel_idx_s = IDXW'(i);
            end else begin
                low_cnt_s = low_cnt_s;
            end
        end
    end

    assign sel_s   = (low_cnt_s == 4'd1);
    assign multi_s = (low_cnt_s > 4'd1);
    // Only meaningful outside IDLE, where the previous sample selected a digit
    assign same_s  = (sel_idx_s == prev_idx_r) && (samp_seg_r == prev_seg_r);

    // Dwell FSM plus capture, frame tracking and pulse generation
    always_comb begin
        state_n_s  = state_r;
        cnt_n_s    = cnt_r;
        capture_s  = 1'b0;
        hex_n_s    = hex_out;
        dp_n_s     = dp_out;
        valid_n_s  = dig_valid;
        seen_n_s   = seen_r;
        seen_upd_s = seen_r;
        frame_n_s  = 1'b0;
        err_n_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (sel_s) begin
                    state_n_s = ST_SETTLE;
                    cnt_n_s   = 8'd1;
                end else begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (sel_s && same_s) begin
                    cnt_n_s = cnt_r + 8'd1;
                    if ((cnt_r + 8'd1) == CNT_TGT) begin
                        capture_s = 1'b1;
                        state_n_s = ST_HELD;
                    end else begin
                        state_n_s = ST_SETTLE;
                    end
                end else if (sel_s) begin
                    state_n_s = ST_SETTLE;
                    cnt_n_s   = 8'd1;
                end else begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = 8'd0;
                end
            end
            ST_HELD: begin
                if (sel_s && same_s) begin
                    state_n_s = ST_HELD;
                end else if (sel_s) begin
                    state_n_s = ST_SETTLE;
                    cnt_n_s   = 8'd1;
                end else begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = 8'd0;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = 8'd0;
            end
        endcase

        if (clr) begin
            // Clear wins over any capture and suppresses both pulses
            state_n_s = ST_IDLE;
            cnt_n_s   = 8'd0;
            hex_n_s   = '0;
            dp_n_s    = '0;
            valid_n_s = '0;
            seen_n_s  = '0;
        end else begin
            // Illegal enables pulse only on entry into the condition
            err_n_s = multi_s & ~multi_r;
            if (capture_s) begin
                if (legal_s) begin
                    hex_n_s[{sel_idx_s, 2'b00} +: 4] = nib_s;
                    dp_n_s[sel_idx_s]                = ~samp_seg_r[0];
                    valid_n_s[sel_idx_s]             = 1'b1;
                end else begin
                    valid_n_s[sel_idx_s] = 1'b0;
                    err_n_s              = 1'b1;
                end
                seen_upd_s = seen_r | (NDIG'(1'b1) << sel_idx_s);
                if (&seen_upd_s) begin
                    frame_n_s = 1'b1;
                    seen_n_s  = '0;
                end else begin
                    seen_n_s = seen_upd_s;
                end
            end else begin
                seen_n_s = seen_r;
            end
        end
    end

    // Register pins, FSM state and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_seg_r <= 8'hFF;
            samp_dig_r <= '1;
            prev_seg_r <= 8'hFF;
            prev_idx_r <= '0;
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            multi_r    <= 1'b0;
            seen_r     <= '0;
            hex_out    <= '0;
            dp_out     <= '0;
            dig_valid  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            samp_seg_r <= seg_n;
            samp_dig_r <= dig_n;
            prev_seg_r <= samp_seg_r;
            prev_idx_r <= sel_idx_s;
            state_r    <= state_n_s;
            cnt_r      <= cnt_n_s;
            multi_r    <= multi_s;
            seen_r     <= seen_n_s;
            hex_out    <= hex_n_s;
            dp_out     <= dp_n_s;
            dig_valid  <= valid_n_s;
            frame_done <= frame_n_s;
            err        <= err_n_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios followed by a
// randomized scan, all checked every cycle against a run-length reference model.
module tb_seg_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic               clk;
    logic               rst;
    logic [7:0]         seg_n;
    logic [NDIG-1:0]    dig_n;
    logic               clr;
    logic [4*NDIG-1:0]  hex_out;
    logic [NDIG-1:0]    dp_out;
    logic [NDIG-1:0]    dig_valid;
    logic               frame_done;
    logic               err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int frame_seen = 0;

    // Reference model state
    logic [6:0]         pat_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                          7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    logic [7:0]         scan_seg [4] = '{8'h03, 8'h9F, 8'h11, 8'h71};
    logic [4*NDIG-1:0]  m_hex = '0;
    logic [NDIG-1:0]    m_dp = '0;
    logic [NDIG-1:0]    m_valid = '0;
    logic [NDIG-1:0]    m_seen = '0;
    logic               m_frame = 1'b0;
    logic               m_err = 1'b0;
    logic               m_multi = 1'b0;
    logic [7:0]         m_sseg = 8'hFF;
    logic [NDIG-1:0]    m_sdig = '1;
    logic [7:0]         m_lseg = 8'hFF;
    int                 m_lidx = 0;
    int                 run = 0;
    logic [15:0]        hex_keep;

    seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .clr        (clr),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .dig_valid  (dig_valid),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: the sample taken on the previous edge is judged now
    task automatic model_edge(input logic [7:0] s, input logic [NDIG-1:0] d,
                              input logic c, input logic r);
        int nlow;
        int idx;
        int code;
        m_err   = 1'b0;
        m_frame = 1'b0;
        if (r) begin
            m_hex = '0; m_dp = '0; m_valid = '0; m_seen = '0;
            run = 0; m_multi = 1'b0; m_sseg = 8'hFF; m_sdig = '1;
            return;
        end
        nlow = 0;
        idx  = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (m_sdig[i] == 1'b0) begin
                nlow++;
                idx = i;
            end
        end
        if (c) begin
            m_hex = '0; m_dp = '0; m_valid = '0; m_seen = '0;
            run = 0;
        end else begin
            if (nlow >= 2 && !m_multi) m_err = 1'b1;
            if (nlow == 1) begin
                if (run > 0 && idx == m_lidx && m_sseg == m_lseg) run++;
                else run = 1;
            end else begin
                run = 0;
            end
            if (nlow == 1 && run == STABLE) begin
                code = -1;
                for (int k = 0; k < 16; k++)
                    if (pat_tbl[k] == m_sseg[7:1]) code = k;
                if (code >= 0) begin
                    m_hex[4*idx +: 4] = 4'(code);
                    m_dp[idx]         = ~m_sseg[0];
                    m_valid[idx]      = 1'b1;
                end else begin
                    m_valid[idx] = 1'b0;
                    m_err        = 1'b1;
                end
                m_seen[idx] = 1'b1;
                if (&m_seen) begin
                    m_frame = 1'b1;
                    m_seen  = '0;
                end
            end
        end
        m_multi = (nlow >= 2);
        m_lidx  = idx;
        m_lseg  = m_sseg;
        m_sseg  = s;
        m_sdig  = d;
    endtask

    task automatic step(input logic [7:0] s, input logic [NDIG-1:0] d,
                        input logic c, input logic r);
        seg_n = s;
        dig_n = d;
        clr   = c;
        rst   = r;
        @(posedge clk);
        model_edge(s, d, c, r);
        #1;
        if (err === 1'b1) err_seen++;
        if (frame_done === 1'b1) frame_seen++;
        check("hex_out", 32'(hex_out), 32'(m_hex));
        check("dp_out", 32'(dp_out), 32'(m_dp));
        check("dig_valid", 32'(dig_valid), 32'(m_valid));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        check("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        logic [NDIG-1:0] dsel;
        logic [NDIG-1:0] dpick;
        logic [7:0]      spick;
        logic [6:0]      ppick;
        int              pick;
        int              len;

        seg_n = 8'hFF; dig_n = 4'hF; clr = 1'b0; rst = 1'b1;

        // Reset state
        step(8'hFF, 4'hF, 1'b0, 1'b1);
        step(8'hFF, 4'hF, 1'b0, 1'b1);
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_valid", 32'(dig_valid), 32'h0);
        check("rst_pulses", 32'({frame_done, err}), 32'h0);

        // Single digit dwell: capture lands on the fifth edge
        err_seen = 0;
        for (int n = 1; n <= 6; n++) begin
            step(8'h25, 4'b1110, 1'b0, 1'b0);
            if (n == 4) check("dwell_early_valid", 32'(dig_valid[0]), 32'h0);
            if (n == 5) begin
                check("dwell_hex0", 32'(hex_out[3:0]), 32'h2);
                check("dwell_valid0", 32'(dig_valid[0]), 32'h1);
            end
        end
        check("dwell_err", 32'(err_seen), 32'h0);
        step(8'hFF, 4'hF, 1'b0, 1'b0);
        step(8'hFF, 4'hF, 1'b1, 1'b0);

        // Full frame scan of four digits
        frame_seen = 0;
        for (int dg = 0; dg < 4; dg++) begin
            dsel = 4'b0001 << dg;
            for (int n = 1; n <= 5; n++) begin
                step(scan_seg[dg], ~dsel, 1'b0, 1'b0);
                if (dg == 3 && n == 5) check("scan_frame_edge", 32'(frame_done), 32'h1);
            end
        end
        check("scan_hex", 32'(hex_out), 32'hFA10);
        check("scan_valid", 32'(dig_valid), 32'hF);
        check("scan_dp", 32'(dp_out), 32'h0);
        check("scan_frames", 32'(frame_seen), 32'h1);

        // Unstable segments never capture
        err_seen = 0;
        hex_keep = hex_out;
        for (int n = 0; n < 12; n++)
            step(((n / 2) % 2 == 0) ? 8'h03 : 8'h25, 4'b1101, 1'b0, 1'b0);
        check("toggle_hex", 32'(hex_out), 32'(hex_keep));
        check("toggle_err", 32'(err_seen), 32'h0);

        // Illegal pattern on digit 1
        err_seen = 0;
        for (int n = 0; n < 5; n++) step(8'hFF, 4'b1101, 1'b0, 1'b0);
        check("illegal_valid1", 32'(dig_valid[1]), 32'h0);
        check("illegal_hex1", 32'(hex_out[7:4]), 32'h1);
        check("illegal_err", 32'(err_seen), 32'h1);

        // Two digits enabled at once
        err_seen = 0;
        for (int n = 0; n < 4; n++) step(8'h25, 4'b1100, 1'b0, 1'b0);
        check("multi_err", 32'(err_seen), 32'h1);

        // Reset in the middle of a dwell discards the partial count
        for (int n = 0; n < 3; n++) step(8'h25, 4'b1011, 1'b0, 1'b0);
        step(8'h25, 4'b1011, 1'b0, 1'b1);
        check("midrst_hex", 32'(hex_out), 32'h0);
        for (int n = 1; n <= 5; n++) begin
            step(8'h25, 4'b1011, 1'b0, 1'b0);
            if (n == 4) check("midrst_early_valid", 32'(dig_valid), 32'h0);
        end
        check("midrst_valid2", 32'(dig_valid[2]), 32'h1);
        check("midrst_hex2", 32'(hex_out[11:8]), 32'h2);

        // Clear coincident with a capture
        for (int n = 1; n <= 5; n++) step(8'h03, 4'b1011, (n == 5) ? 1'b1 : 1'b0, 1'b0);
        check("clr_hex", 32'(hex_out), 32'h0);
        check("clr_dp_valid", 32'({dp_out, dig_valid}), 32'h0);
        check("clr_pulses", 32'({frame_done, err}), 32'h0);

        // Randomized dwells
        for (int n = 0; n < 120; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick == 0) begin
                dpick = 4'hF;
            end else if (pick == 1) begin
                dsel  = 4'b0011 << $urandom_range(0, 2);
                dpick = ~dsel;
            end else begin
                dsel  = 4'b0001 << $urandom_range(0, 3);
                dpick = ~dsel;
            end
            if ($urandom_range(0, 4) == 0) begin
                spick = 8'($urandom);
            end else begin
                ppick = pat_tbl[$urandom_range(0, 15)];
                spick = {ppick, 1'($urandom_range(0, 1))};
            end
            len = int'($urandom_range(1, 7));
            for (int j = 0; j < len; j++)
                step(spick, dpick, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning the number of scanned digits (2..8).
REQ-002 SHALL have parameter STABLE_CYC, default 4, meaning the consecutive identical samples required before capture (2..255).
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port seg_n, input, width 8: active-low segment bus, bit7..bit1 = a..g, bit0 = dp.
REQ-006 SHALL have port dig_n, input, width NDIG: active-low digit enables from the scanning driver.
REQ-007 SHALL have port clr, input, width 1: synchronous clear of captured data and frame tracking.
REQ-008 SHALL have port hex_out, output, width 4*NDIG: decoded nibble per digit, digit i at [4i+3:4i].
REQ-009 SHALL have port dp_out, output, width NDIG: decimal point per digit, 1 = lit.
REQ-010 SHALL have port dig_valid, output, width NDIG: 1 = last capture for that digit was a legal pattern.
REQ-011 SHALL have port frame_done, output, width 1: one-cycle pulse when every digit has been captured since the last frame.
REQ-012 SHALL have port err, output, width 1: one-cycle pulse on an illegal pattern or illegal enable combination.

Function
REQ-013 SHALL register seg_n and dig_n once, then operate only on the registered samples.
REQ-014 SHALL treat a sample as "selected digit i" only when exactly one dig_n bit (bit i) is low.
REQ-015 SHALL use states IDLE (no digit selected), SETTLE (counting stability) and HELD (captured, waiting for a change).
REQ-016 SHALL move IDLE->SETTLE with cnt=1 on the first sample that selects a digit.
REQ-017 In SETTLE, SHALL increment cnt while digit index and seg sample equal the previous sample; on any difference, SHALL restart with cnt=1, or go to IDLE if no digit is selected.
REQ-018 SHALL capture when cnt reaches STABLE_CYC, then enter HELD; capture happens exactly once per dwell.
REQ-019 In HELD, SHALL remain while the sample is unchanged, and on change SHALL behave as in REQ-017.
REQ-020 SHALL make the pins-to-output latency STABLE_CYC+1 clock edges when the pins are held constant.
REQ-021 Decode table (seg_n[7:1], hex): 0=01,1=4F,2=12,3=06,4=4C,5=24,6=20,7=0F,8=00,9=04,A=08,B=60,C=31,D=42,E=30,F=38.
REQ-022 On a legal capture, SHALL write hex_out[i], set dp_out[i]=~seg_n[0], set dig_valid[i]=1 and set seen[i].
REQ-023 On an illegal pattern, SHALL hold hex_out[i] and dp_out[i], clear dig_valid[i], set seen[i] and pulse err.
REQ-024 When two or more dig_n bits are low, SHALL pulse err once on entry to that condition and treat the sample as IDLE.
REQ-025 When seen becomes all-ones, SHALL pulse frame_done on the same edge as the completing capture and clear seen; a repeat capture of an already-seen digit SHALL NOT advance the frame.
REQ-026 clr SHALL have priority over a simultaneous capture: hex_out, dp_out, dig_valid and seen are cleared, the state goes to IDLE, and no pulse is issued that cycle.

Reset
REQ-027 While rst=1 at an edge, SHALL set: hex_out=0, dp_out=0, dig_valid=0, frame_done=0, err=0, seen=0, cnt=0, state=IDLE, and the sample registers to all-ones (nothing selected).
REQ-028 Reset mid-dwell SHALL discard partial counts; a fresh STABLE_CYC dwell is required after release.

Structure
REQ-029 SHALL place the 16-entry pattern table, the state encoding and the default parameter values in a shared package, seg_pkg.
REQ-030 SHALL isolate the pattern-to-nibble lookup in a combinational sub-module, seg7_to_hex (7-bit input; outputs nibble and legal flag).

Verification
REQ-031 Hold dig_n=1110, seg_n=0x25 for 6 cycles (STABLE_CYC=4) -> hex_out[3:0]=2, dig_valid[0]=1 after edge 5, err=0.
REQ-032 Scan digits 0..3 with 0x03,0x9F,0x11,0x71, each 5 cycles -> hex_out=0xFA10, single frame_done pulse on the digit-3 capture edge.
REQ-033 Toggle seg_n every 2 cycles on digit 1 -> no capture, hex_out unchanged, no err.
REQ-034 Hold dig_n=1101, seg_n=0xFF for 5 cycles -> dig_valid[1]=0, one err pulse, hex_out[7:4] unchanged.
REQ-035 Hold dig_n=1100 -> exactly one err pulse; assert rst mid-dwell, then clr during a capture -> all outputs 0.
